axis_video_frame_sink: RTL and testbench

AXI4-Stream video receiver that terminates the VFP mm2s output stream (tvalid/tready/tuser/tlast/tdata) in the bench and in loopback builds. It drives tready with a selectable backpressure pattern and rebuilds frame geometry from tuser/tlast. It emits per-pixel red/green/blue with x/y coordinates and an end-of-frame pulse. It also flags protocol and geometry violations against the configured image size.

---
 rtl/axis_video_frame_sink_pkg.sv | 29 ++
 rtl/axis_video_frame_sink_if.sv | 16 +
 rtl/axis_video_frame_sink_ready_gen.sv | 41 ++++
 rtl/axis_video_frame_sink.sv | 158 +++++++++++++++
 tb/tb_axis_video_frame_sink.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/axis_video_frame_sink_pkg.sv
// Shared types and constants for the AXI4-Stream video frame sink.
package axis_video_frame_sink_pkg;

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    ACTIVE   = 2'd1,
    DRAIN    = 2'd2
  } sink_state_t;

  // tready pattern selection
  localparam logic [1:0] READY_ALWAYS = 2'b00;
  localparam logic [1:0] READY_TOGGLE = 2'b01;
  localparam logic [1:0] READY_LFSR   = 2'b10;
  localparam logic [1:0] READY_OFF    = 2'b11;

  localparam int PIX_W = 8;

  typedef struct packed {
    logic [PIX_W-1:0] red;
    logic [PIX_W-1:0] green;
    logic [PIX_W-1:0] blue;
  } rgb_pixel_t;

  // Fibonacci LFSR step, polynomial x^16+x^14+x^13+x^11+1
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/axis_video_frame_sink_if.sv
// AXI4-Stream video bus between the mm2s source and the frame sink.
// Handshake: a beat transfers on a rising clk edge where tvalid and tready
// are both 1. The source holds tvalid/tuser/tlast/tdata stable until that
// edge; tready is produced without looking at tvalid.
interface axis_video_frame_sink_if #(
  parameter int TDATA_WIDTH = 24
);
  logic                   tvalid;
  logic                   tready;
  logic                   tuser;
  logic                   tlast;
  logic [TDATA_WIDTH-1:0] tdata;

  modport master (output tvalid, output tuser, output tlast, output tdata, input tready);
  modport slave  (input tvalid, input tuser, input tlast, input tdata, output tready);
endinterface

// File: rtl/axis_video_frame_sink_ready_gen.sv
// Registered tready generator: always, toggle, LFSR or hold-low patterns.
module axis_video_frame_sink_ready_gen
  import axis_video_frame_sink_pkg::*;
#(
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] mode,
  output logic       tready
);

  logic [15:0] lfsr_q;
  logic        toggle_q;
  logic        ready_d;

  // Pattern mux; the toggle flop starts at 0 so the first ready is 1
  always_comb begin
    ready_d = 1'b0;
    case (mode)
      READY_ALWAYS: ready_d = 1'b1;
      READY_TOGGLE: ready_d = ~toggle_q;
      READY_LFSR:   ready_d = lfsr_q[0];
      default:      ready_d = 1'b0;
    endcase
  end

  // LFSR and toggle free-run every cycle; tready is the registered mux output
  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q   <= LFSR_SEED;
      toggle_q <= 1'b0;
      tready   <= 1'b0;
    end else begin
      lfsr_q   <= lfsr_next(lfsr_q);
      toggle_q <= ~toggle_q;
      tready   <= ready_d;
    end
  end

endmodule

// File: rtl/axis_video_frame_sink.sv
// AXI4-Stream video sink: rebuilds frame geometry from tuser/tlast, emits
// pixels with coordinates, and flags protocol/geometry violations.
module axis_video_frame_sink
  import axis_video_frame_sink_pkg::*;
#(
  parameter int          TDATA_WIDTH  = 24,
  parameter int          i_data_width = 8,
  parameter int          IMG_WIDTH    = 64,
  parameter int          IMG_HEIGHT   = 48,
  parameter logic [15:0] LFSR_SEED    = 16'hACE1
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [1:0]              iReadyMode,
  axis_video_frame_sink_if.slave  s_axis,
  output logic                    valid,
  output logic [i_data_width-1:0] red,
  output logic [i_data_width-1:0] green,
  output logic [i_data_width-1:0] blue,
  output logic [15:0]             xCord,
  output logic [15:0]             yCord,
  output logic                    endOfFrame,
  output logic                    errSofEarly,
  output logic                    errEolEarly,
  output logic                    errEolLate,
  output logic [15:0]             frameCount,
  output logic [15:0]             errCount,
  output logic [15:0]             dropCount,
  output sink_state_t             fsm_state
);

  localparam logic [15:0] X_LAST = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] Y_LAST = 16'(IMG_HEIGHT - 1);

  sink_state_t state_q, state_d;
  logic [15:0] x_q, y_q, x_d, y_d;
  logic [15:0] cx, cy;
  logic        tready_q, transfer;
  logic        emit, drop, eof, sof_err, eol_early, eol_late;

  axis_video_frame_sink_ready_gen #(.LFSR_SEED(LFSR_SEED)) u_ready_gen (
    .clk    (clk),
    .reset  (reset),
    .mode   (iReadyMode),
    .tready (tready_q)
  );

  assign s_axis.tready = tready_q;
  assign transfer      = s_axis.tvalid & tready_q;
  assign fsm_state     = state_q;

  // Next-state: place the beat, then apply the line-end rules to its position.
  // A restart beat (tuser inside a frame) reports only errSofEarly; a broken
  // line on that same beat still drains, just without a second error pulse.
  always_comb begin
    state_d   = state_q;
    x_d       = x_q;
    y_d       = y_q;
    cx        = x_q;
    cy        = y_q;
    emit      = 1'b0;
    drop      = 1'b0;
    eof       = 1'b0;
    sof_err   = 1'b0;
    eol_early = 1'b0;
    eol_late  = 1'b0;
    if (transfer) begin
      if (s_axis.tuser) begin
        emit    = 1'b1;
        cx      = 16'd0;
        cy      = 16'd0;
        sof_err = (state_q == ACTIVE);
      end else if (state_q == ACTIVE) begin
        emit = 1'b1;
      end else begin
        drop = 1'b1;
      end
      if (emit) begin
        if (s_axis.tlast && (cx != X_LAST)) begin
          eol_early = ~sof_err;
          state_d   = DRAIN;
          x_d       = 16'd0;
          y_d       = 16'd0;
        end else if (!s_axis.tlast && (cx == X_LAST)) begin
          eol_late = ~sof_err;
          state_d  = DRAIN;
          x_d      = 16'd0;
          y_d      = 16'd0;
        end else if (s_axis.tlast) begin
          x_d = 16'd0;
          if (cy == Y_LAST) begin
            eof     = 1'b1;
            state_d = WAIT_SOF;
            y_d     = 16'd0;
          end else begin
            state_d = ACTIVE;
            y_d     = cy + 16'd1;
          end
        end else begin
          state_d = ACTIVE;
          x_d     = cx + 16'd1;
          y_d     = cy;
        end
      end
    end
  end

  // FSM and position registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= WAIT_SOF;
      x_q     <= 16'd0;
      y_q     <= 16'd0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      y_q     <= y_d;
    end
  end

  // Registered pixel, strobe and counter outputs; data holds when idle
  always_ff @(posedge clk) begin
    if (reset) begin
      valid       <= 1'b0;
      red         <= '0;
      green       <= '0;
      blue        <= '0;
      xCord       <= 16'd0;
      yCord       <= 16'd0;
      endOfFrame  <= 1'b0;
      errSofEarly <= 1'b0;
      errEolEarly <= 1'b0;
      errEolLate  <= 1'b0;
      frameCount  <= 16'd0;
      errCount    <= 16'd0;
      dropCount   <= 16'd0;
    end else begin
      valid       <= emit;
      endOfFrame  <= eof;
      errSofEarly <= sof_err;
      errEolEarly <= eol_early;
      errEolLate  <= eol_late;
      if (emit) begin
        red   <= s_axis.tdata[TDATA_WIDTH-1 -: i_data_width];
        green <= s_axis.tdata[2*i_data_width-1 -: i_data_width];
        blue  <= s_axis.tdata[i_data_width-1:0];
        xCord <= cx;
        yCord <= cy;
      end
      if (eof) frameCount <= frameCount + 16'd1;
      if ((sof_err | eol_early | eol_late) && (errCount != 16'hFFFF))
        errCount <= errCount + 16'd1;
      if (drop && (dropCount != 16'hFFFF))
        dropCount <= dropCount + 16'd1;
    end
  end

endmodule

// File: tb/tb_axis_video_frame_sink.sv
// Directed, table-driven bench for axis_video_frame_sink (4x2 image).
module tb_axis_video_frame_sink;
  import axis_video_frame_sink_pkg::*;

  localparam int W = 4;
  localparam int H = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [1:0]  mode = READY_ALWAYS;
  logic        valid, endOfFrame, errSofEarly, errEolEarly, errEolLate;
  logic [7:0]  red, green, blue;
  logic [15:0] xCord, yCord, frameCount, errCount, dropCount;
  sink_state_t fsm_state;
  int          cyc = 0;

  axis_video_frame_sink_if #(.TDATA_WIDTH(24)) axis ();

  axis_video_frame_sink #(
    .TDATA_WIDTH(24), .i_data_width(8), .IMG_WIDTH(W), .IMG_HEIGHT(H), .LFSR_SEED(16'hACE1)
  ) dut (
    .clk(clk), .reset(reset), .iReadyMode(mode), .s_axis(axis),
    .valid(valid), .red(red), .green(green), .blue(blue),
    .xCord(xCord), .yCord(yCord), .endOfFrame(endOfFrame),
    .errSofEarly(errSofEarly), .errEolEarly(errEolEarly), .errEolLate(errEolLate),
    .frameCount(frameCount), .errCount(errCount), .dropCount(dropCount),
    .fsm_state(fsm_state)
  );

  // clock / cycle counter
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    bit          user;
    bit          last;
    logic [23:0] data;
    bit          exp_valid;
    logic [15:0] exp_x;
    logic [15:0] exp_y;
    bit          exp_eof;
    bit          exp_sof;
    bit          exp_early;
    bit          exp_late;
  } vec_t;

  vec_t vecs[$];
  int   cmp_count = 0;
  int   mis_count = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    cmp_count++;
    if (act !== exp) begin
      mis_count++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void add(input bit user, input bit last, input logic [23:0] data,
                              input bit ev, input int ex, input int ey, input bit eof,
                              input bit sof, input bit early, input bit late);
    vec_t v;
    v.user = user; v.last = last; v.data = data; v.exp_valid = ev;
    v.exp_x = 16'(ex); v.exp_y = 16'(ey); v.exp_eof = eof;
    v.exp_sof = sof; v.exp_early = early; v.exp_late = late;
    vecs.push_back(v);
  endfunction

  // clean frame beats k = first..last, k = y*W + x, tdata = 0x010203 + k
  function automatic void add_frame(input int first, input int last);
    for (int k = first; k <= last; k++)
      add(k == 0, (k % W) == W - 1, 24'h010203 + 24'(k), 1'b1, k % W, k / W,
          k == W * H - 1, 1'b0, 1'b0, 1'b0);
  endfunction

  function automatic logic [15:0] model_lfsr(input logic [15:0] s);
    logic fb;
    fb = s[15] ^ s[13] ^ s[12] ^ s[10];
    return {s[14:0], fb};
  endfunction

  // driver: present a beat, wait (bounded) for the transfer edge, return #1 after it
  task automatic drive_beat(input vec_t v, output bit done);
    axis.tvalid = 1'b1;
    axis.tuser  = v.user;
    axis.tlast  = v.last;
    axis.tdata  = v.data;
    done = 1'b0;
    for (int c = 0; c < 40 && !done; c++) begin
      if (axis.tready === 1'b1) done = 1'b1;
      @(posedge clk); #1;
    end
  endtask

  task automatic apply_vecs(input string tag);
    bit         done;
    rgb_pixel_t p;
    foreach (vecs[i]) begin
      drive_beat(vecs[i], done);
      check($sformatf("%s[%0d].handshake", tag, i), 32'(done), 32'd1);
      if (done) begin
        p = vecs[i].data;
        check($sformatf("%s[%0d].valid", tag, i), 32'(valid), 32'(vecs[i].exp_valid));
        if (vecs[i].exp_valid) begin
          check($sformatf("%s[%0d].x", tag, i), 32'(xCord), 32'(vecs[i].exp_x));
          check($sformatf("%s[%0d].y", tag, i), 32'(yCord), 32'(vecs[i].exp_y));
          check($sformatf("%s[%0d].rgb", tag, i), {8'd0, red, green, blue},
                {8'd0, p.red, p.green, p.blue});
        end
        check($sformatf("%s[%0d].eof", tag, i), 32'(endOfFrame), 32'(vecs[i].exp_eof));
        check($sformatf("%s[%0d].errs", tag, i), {29'd0, errSofEarly, errEolEarly, errEolLate},
              {29'd0, vecs[i].exp_sof, vecs[i].exp_early, vecs[i].exp_late});
      end
    end
    axis.tvalid = 1'b0;
    axis.tuser  = 1'b0;
    axis.tlast  = 1'b0;
    vecs.delete();
  endtask

  task automatic do_reset();
    axis.tvalid = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    reset = 1'b0;
  endtask

  task automatic check_idle_outputs(input string tag);
    check({tag, ".tready"}, 32'(axis.tready), 32'd0);
    check({tag, ".valid"}, 32'(valid), 32'd0);
    check({tag, ".pix"}, {8'd0, red, green, blue}, 32'd0);
    check({tag, ".xy"}, {xCord, yCord}, 32'd0);
    check({tag, ".strobes"}, {28'd0, endOfFrame, errSofEarly, errEolEarly, errEolLate}, 32'd0);
    check({tag, ".counts"}, {frameCount, errCount}, 32'd0);
    check({tag, ".drops"}, 32'(dropCount), 32'd0);
    check({tag, ".state"}, 32'(fsm_state), 32'(WAIT_SOF));
  endtask

  initial begin
    int          c0;
    logic [15:0] m;
    axis.tvalid = 1'b0; axis.tuser = 1'b0; axis.tlast = 1'b0; axis.tdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check_idle_outputs("reset");
    reset = 1'b0;

    // 1: clean frame, always ready
    add_frame(0, W * H - 1);
    apply_vecs("s1");
    check("s1.frameCount", 32'(frameCount), 32'd1);
    check("s1.errCount", 32'(errCount), 32'd0);
    @(posedge clk); #1;
    check("s1.idle_strobes", {30'd0, valid, endOfFrame}, 32'd0);

    // 2: toggle pattern, then the same frame under toggle backpressure
    mode = READY_TOGGLE;
    do_reset();
    for (int n = 1; n <= 6; n++) begin
      @(posedge clk); #1;
      check($sformatf("s2.toggle[%0d]", n), 32'(axis.tready), 32'(n % 2));
    end
    do_reset();
    c0 = cyc;
    add_frame(0, W * H - 1);
    apply_vecs("s2");
    check("s2.cycles", 32'(cyc - c0), 32'd16);
    check("s2.frameCount", 32'(frameCount), 32'd1);

    // LFSR pattern against an independent model, then a frame under it
    mode = READY_LFSR;
    do_reset();
    m = 16'hACE1;
    for (int n = 0; n < 20; n++) begin
      @(posedge clk); #1;
      check($sformatf("lfsr.tready[%0d]", n), 32'(axis.tready), 32'(m[0]));
      m = model_lfsr(m);
    end
    add_frame(0, W * H - 1);
    apply_vecs("lfsr");
    check("lfsr.frameCount", 32'(frameCount), 32'd1);

    // hold-low pattern
    mode = READY_OFF;
    repeat (2) @(posedge clk);
    #1;
    for (int n = 0; n < 4; n++) begin
      @(posedge clk); #1;
      check($sformatf("off.tready[%0d]", n), 32'(axis.tready), 32'd0);
    end
    mode = READY_ALWAYS;

    // 3: early tlast at x=2, drain 5 beats, then a clean frame
    do_reset();
    add(1, 0, 24'h112233, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 24'h112234, 1, 1, 0, 0, 0, 0, 0);
    add(0, 1, 24'h112235, 1, 2, 0, 0, 0, 1, 0);
    for (int k = 0; k < 5; k++) add(0, k[0], 24'h300000 + 24'(k), 0, 0, 0, 0, 0, 0, 0);
    apply_vecs("s3");
    check("s3.dropCount", 32'(dropCount), 32'd5);
    check("s3.errCount", 32'(errCount), 32'd1);
    add_frame(0, W * H - 1);
    apply_vecs("s3b");
    check("s3.frameCount", 32'(frameCount), 32'd1);

    // 4: missing tlast at x=3, discarded tail, then a clean frame
    do_reset();
    add(1, 0, 24'h405060, 1, 0, 0, 0, 0, 0, 0);
    add(0, 0, 24'h405061, 1, 1, 0, 0, 0, 0, 0);
    add(0, 0, 24'h405062, 1, 2, 0, 0, 0, 0, 0);
    add(0, 0, 24'h405063, 1, 3, 0, 0, 0, 0, 1);
    add(0, 0, 24'h405064, 0, 0, 0, 0, 0, 0, 0);
    add(0, 1, 24'h405065, 0, 0, 0, 0, 0, 0, 0);
    apply_vecs("s4");
    check("s4.errCount", 32'(errCount), 32'd1);
    check("s4.dropCount", 32'(dropCount), 32'd2);
    check("s4.frameCount0", 32'(frameCount), 32'd0);
    add_frame(0, W * H - 1);
    apply_vecs("s4b");
    check("s4.frameCount1", 32'(frameCount), 32'd1);

    // 5: tuser re-asserted at (2,1) restarts the frame at (0,0)
    do_reset();
    add_frame(0, 5);
    add(1, 0, 24'hAA5501, 1, 0, 0, 0, 1, 0, 0);
    add_frame(1, W * H - 1);
    apply_vecs("s5");
    check("s5.frameCount", 32'(frameCount), 32'd1);
    check("s5.errCount", 32'(errCount), 32'd1);

    // 6: reset pulsed mid-frame after pixel (1,1)
    do_reset();
    add_frame(0, 5);
    apply_vecs("s6");
    reset = 1'b1;
    @(posedge clk); #1;
    check_idle_outputs("s6.reset");
    reset = 1'b0;
    add_frame(0, W * H - 1);
    apply_vecs("s6b");
    check("s6.frameCount", 32'(frameCount), 32'd1);
    check("s6.errCount", 32'(errCount), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_count, mis_count);
    $finish;
  end

endmodule
